data_memory_mp: RTL and testbench

//  Parametrised multi-port word RAM shared by CPU, keyboard and VGA readers.
//  CPU gets one read/write port with byte enables. Keyboard writes go through a

---
 rtl/data_memory_mp.sv | 177 +++++++++++++++++
 tb/tb_data_memory_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mp.sv
// data_memory_mp: multi-port word RAM with a CPU byte-enable port, a keyboard write
// queue, N_VID video read ports and a post-reset zeroing scrub. Option macro: VID_READ_REG_EN.
module data_memory_mp #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 64,
  parameter int N_VID         = 4,
  parameter int KB_FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [WIDTH/8-1:0]     be,
  input  logic [31:0]            a,
  input  logic [WIDTH-1:0]       wd,
  output logic [WIDTH-1:0]       rd,
  input  logic                   kb_valid,
  output logic                   kb_ready,
  input  logic [31:0]            kb_addr,
  input  logic [WIDTH-1:0]       kb_data,
  output logic [WIDTH-1:0]       code_key,
  input  logic [N_VID*32-1:0]    vid_addr,
  output logic [N_VID*WIDTH-1:0] vid_data,
  output logic                   busy,
  output logic                   addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam int PW = $clog2(KB_FIFO_DEPTH);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [31:0]      q_addr [KB_FIFO_DEPTH];
  logic [WIDTH-1:0] q_data [KB_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic                   run;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   head_ok;
  logic                   vid_oor;
  logic [N_VID*WIDTH-1:0] vid_word;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'(addr >> 2);
  endfunction

  assign run      = (state == RUN);
  assign full     = (count == (PW+1)'(KB_FIFO_DEPTH));
  assign empty    = (count == '0);
  assign kb_ready = run && !full;
  assign push     = kb_valid && kb_ready;
  // The queue only drains in cycles the CPU is not writing, which preserves
  // CPU-then-keyboard ordering for the same address.
  assign pop      = run && !we && !empty;
  assign head_ok  = in_range(q_addr[rd_ptr]);

  always_comb begin
    rd       = '0;
    code_key = '0;
    vid_word = '0;
    vid_oor  = 1'b0;
    if (run && in_range(a)) begin
      rd = mem[word_idx(a)];
    end else begin
      rd = '0;
    end
    if (run && in_range(kb_addr)) begin
      code_key = mem[word_idx(kb_addr)];
    end else begin
      code_key = '0;
    end
    for (int k = 0; k < N_VID; k++) begin
      if (!in_range(vid_addr[32*k +: 32])) begin
        vid_oor = 1'b1;
      end else if (run) begin
        vid_word[WIDTH*k +: WIDTH] = mem[word_idx(vid_addr[32*k +: 32])];
      end else begin
        vid_word[WIDTH*k +: WIDTH] = '0;
      end
    end
  end

  // Single array write port: scrub in CLEAR, then CPU writes with kb pops in idle cycles.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_ptr] <= '0;
    end else if (we) begin
      if (in_range(a)) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            mem[word_idx(a)][8*i +: 8] <= wd[8*i +: 8];
          end
        end
      end
    end else if (pop && head_ok) begin
      mem[word_idx(q_addr[rd_ptr])] <= q_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= kb_addr;
      q_data[wr_ptr] <= kb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      addr_err <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase

      if (!in_range(a) || vid_oor || (pop && !head_ok)) begin
        addr_err <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef VID_READ_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_data <= '0;
    end else begin
      vid_data <= vid_word;
    end
  end
`else
  assign vid_data = vid_word;
`endif

endmodule

// File: tb/tb_data_memory_mp.sv
// tb_data_memory_mp: randomized and directed checks of data_memory_mp against a
// queue-based behavioural model of the memory, keyboard queue and scrub.
module tb_data_memory_mp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int N_VID = 4;
  localparam int QD    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   we;
  logic [3:0]             be;
  logic [31:0]            a;
  logic [31:0]            wd;
  logic [31:0]            rd;
  logic                   kb_valid;
  logic                   kb_ready;
  logic [31:0]            kb_addr;
  logic [31:0]            kb_data;
  logic [31:0]            code_key;
  logic [N_VID*32-1:0]    vid_addr;
  logic [N_VID*WIDTH-1:0] vid_data;
  logic                   busy;
  logic                   addr_err;

  always #5 clk = ~clk;

  data_memory_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_VID(N_VID), .KB_FIFO_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .a(a), .wd(wd), .rd(rd),
    .kb_valid(kb_valid), .kb_ready(kb_ready), .kb_addr(kb_addr), .kb_data(kb_data),
    .code_key(code_key), .vid_addr(vid_addr), .vid_data(vid_data),
    .busy(busy), .addr_err(addr_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [31:0] ref_mem [DEPTH];
  logic [63:0] ref_q [$];
  logic [31:0] ref_vid_q [N_VID];
  int          scrub_left;
  logic        ref_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ok(input logic [31:0] ad);
    return ad[31:8] == 24'd0;
  endfunction

  function automatic logic [31:0] rdw(input logic [31:0] ad);
    if (scrub_left == 0 && ok(ad)) return ref_mem[ad[7:2]];
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    for (int k = 0; k < N_VID; k++) ref_vid_q[k] = 32'd0;
    ref_q.delete();
    scrub_left = DEPTH;
    ref_err = 1'b0;
  endtask

  task automatic model_edge();
    logic        scrub;
    logic        do_push;
    logic        do_pop;
    logic [63:0] h;
    scrub   = (scrub_left > 0);
    do_push = kb_valid && !scrub && (ref_q.size() < QD);
    do_pop  = !scrub && !we && (ref_q.size() > 0);
    for (int k = 0; k < N_VID; k++) begin
      if (!ok(vid_addr[32*k +: 32])) ref_err = 1'b1;
      ref_vid_q[k] = rdw(vid_addr[32*k +: 32]);
    end
    if (!ok(a)) ref_err = 1'b1;
    if (!scrub && we && ok(a)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[a[7:2]][8*i +: 8] = wd[8*i +: 8];
    end
    if (do_pop) begin
      h = ref_q.pop_front();
      if (ok(h[63:32])) ref_mem[h[39:34]] = h[31:0];
      else ref_err = 1'b1;
    end
    if (do_push) ref_q.push_back({kb_addr, kb_data});
    if (scrub) scrub_left--;
  endtask

  // Called at the negative edge with inputs already driven.
  task automatic step();
    logic [31:0] ev;
    #1;
    check_eq("rd", rd, rdw(a));
    check_eq("code_key", code_key, rdw(kb_addr));
    check_eq("kb_ready", {31'd0, kb_ready}, {31'd0, (scrub_left == 0) && (ref_q.size() < QD)});
    check_eq("busy", {31'd0, busy}, {31'd0, scrub_left > 0});
    check_eq("addr_err", {31'd0, addr_err}, {31'd0, ref_err});
    for (int k = 0; k < N_VID; k++) begin
`ifdef VID_READ_REG_EN
      ev = ref_vid_q[k];
`else
      ev = rdw(vid_addr[32*k +: 32]);
`endif
      check_eq($sformatf("vid%0d", k), vid_data[32*k +: 32], ev);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; a = 32'd0; wd = 32'd0;
    kb_valid = 1'b0; kb_addr = 32'd0; kb_data = 32'd0;
    vid_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_kb_ready", {31'd0, kb_ready}, 32'd0);
    check_eq("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_busy(input string tag);
    int bc;
    bc = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      if (busy) bc++;
      a = 32'(i % DEPTH) * 32'd4;
      step();
    end
    check_eq(tag, 32'(bc), 32'd64);
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // 1: scrub length and zeroed array
    count_busy("busy_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i) * 32'd4;
      #1 check_eq("scan_zero", rd, 32'd0);
      step();
    end

    // 2: byte-enable write
    we = 1'b1; a = 32'h8; be = 4'hF; wd = 32'h11223344;
    step();
    be = 4'b0011; wd = 32'hAABBCCDD;
    step();
    idle(); a = 32'h8;
    #1 check_eq("t2_byte_merge", rd, 32'h1122CCDD);
    step();

    // 3: CPU and kb write same address, kb wins
    we = 1'b1; a = 32'h10; be = 4'hF; wd = 32'd1;
    kb_valid = 1'b1; kb_addr = 32'h10; kb_data = 32'd2;
    step();
    idle(); a = 32'h10;
    #1 check_eq("t3_cpu_first", rd, 32'd1);
    step();
    #1 check_eq("t3_kb_final", rd, 32'd2);
    step();

    // 4: queue fills while CPU writes, drains once we drops
    for (int c = 0; c < 5; c++) begin
      we = 1'b1; a = 32'h20; be = 4'hF; wd = 32'(c);
      kb_valid = 1'b1; kb_addr = 32'h24 + 32'(4 * c); kb_data = 32'h100 + 32'(c);
      #1 check_eq("t4_ready", {31'd0, kb_ready}, (c < 2) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    step();
    step();
    a = 32'h24;
    #1 check_eq("t4_kb0", rd, 32'h100);
    a = 32'h28;
    #1 check_eq("t4_kb1", rd, 32'h101);
    a = 32'h2C;
    #1 check_eq("t4_dropped", rd, 32'd0);
    step();

    // randomized traffic, addresses in range and clustered for collisions
    for (int n = 0; n < 400; n++) begin
      we       = ($urandom_range(0, 1) == 1);
      be       = 4'($urandom);
      a        = 32'($urandom_range(0, 47));
      wd       = $urandom;
      kb_valid = ($urandom_range(0, 1) == 1);
      kb_addr  = 32'($urandom_range(0, 47));
      kb_data  = $urandom;
      for (int k = 0; k < N_VID; k++) vid_addr[32*k +: 32] = 32'($urandom_range(0, 255));
      step();
    end
    idle();
    step();
    step();

    // 5: out-of-range video address
    vid_addr[64 +: 32] = 32'h100;
    #1 check_eq("t5_vid2_zero_comb", rdw(32'h100), 32'd0);
    step();
    idle();
    #1 check_eq("t5_err_set", {31'd0, addr_err}, 32'd1);
    step();
    step();
    #1 check_eq("t5_err_sticky", {31'd0, addr_err}, 32'd1);
    do_reset();
    count_busy("busy_cycles_r2");

    // 6: reset with queued writes, then reset again mid-scrub
    we = 1'b1; a = 32'h40; be = 4'hF; wd = 32'h5555AAAA;
    kb_valid = 1'b1; kb_addr = 32'h80; kb_data = 32'hDEADBEEF;
    step();
    kb_addr = 32'h84; kb_data = 32'hCAFEF00D;
    step();
    do_reset();
    for (int i = 0; i < 20; i++) step();
    do_reset();
    count_busy("busy_cycles_r3");
    a = 32'h80;
    #1 check_eq("t6_lost0", rd, 32'd0);
    a = 32'h84;
    #1 check_eq("t6_lost1", rd, 32'd0);
    a = 32'h40;
    #1 check_eq("t6_cpu_cleared", rd, 32'd0);
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
